// File: rtl/axi_front_pkg.sv
// Shared types and response codes for the AXI4-Lite front end.
package axi_front_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    typedef enum logic {
        GNT_WR,
        GNT_RD
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry holding register for an AXI request channel (AW, W or AR).
// ready is registered: low in reset, high whenever the entry is empty.
module axi_lite_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         clear,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] q
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // the source holds valid and data stable until that edge, and ready never waits on valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            full  <= 1'b0;
            q     <= '0;
        end else if (valid && ready) begin
            ready <= 1'b0;
            full  <= 1'b1;
            q     <= data;
        end else if (clear) begin
            ready <= 1'b1;
            full  <= 1'b0;
        end else begin
            ready <= !full;
        end
    end

endmodule

// File: rtl/axi_lite_front.sv
// AXI4-Lite slave front end: buffers AW/W/AR, arbitrates one transaction at a time and
// drives the flat harness register buses, which idle at NOP_ADDR.
module axi_lite_front
    import axi_front_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                RD_LAT   = 1,
    parameter logic [ADDR_W-1:0] NOP_ADDR = 32'hFFFF_FFFC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [ADDR_W-1:0]   axi_wr_addr,
    output logic [DATA_W-1:0]   axi_wr_msg,
    output logic [ADDR_W-1:0]   axi_rd_addr,
    input  logic [DATA_W-1:0]   axi_rd_msg,
    output state_t              state_dbg
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_t                   state, state_nxt;
    grant_t                   last_grant;
    logic [3:0]               lat_cnt;
    logic                     aw_full, w_full, ar_full;
    logic [ADDR_W-1:0]        aw_q, ar_q;
    logic [DATA_W+STRB_W-1:0] w_q;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic                     grant_wr, grant_rd, wr_legal, rd_legal, rd_done;
    logic                     wr_clr, ar_clr;

    axi_lite_hold_reg #(.W(ADDR_W)) u_aw (
        .clk(clk), .reset(reset), .valid(s_awvalid), .data(s_awaddr), .clear(wr_clr),
        .ready(s_awready), .full(aw_full), .q(aw_q)
    );

    axi_lite_hold_reg #(.W(DATA_W + STRB_W)) u_w (
        .clk(clk), .reset(reset), .valid(s_wvalid), .data({s_wstrb, s_wdata}), .clear(wr_clr),
        .ready(s_wready), .full(w_full), .q(w_q)
    );

    axi_lite_hold_reg #(.W(ADDR_W)) u_ar (
        .clk(clk), .reset(reset), .valid(s_arvalid), .data(s_araddr), .clear(ar_clr),
        .ready(s_arready), .full(ar_full), .q(ar_q)
    );

    assign {w_strb, w_data} = w_q;
    assign state_dbg        = state;

    // On a tie the class that did not win last time gets the grant.
    always_comb begin
        grant_wr = (state == IDLE) && aw_full && w_full && (!ar_full || last_grant == GNT_RD);
        grant_rd = (state == IDLE) && ar_full && !grant_wr;
        wr_legal = (w_strb == '1) && (aw_q != NOP_ADDR);
        rd_legal = (ar_q != NOP_ADDR);
        rd_done  = (state == RD_WAIT) && (lat_cnt == LAT_LAST);
        wr_clr   = (state == WR_ISSUE);
        ar_clr   = rd_done || (grant_rd && !rd_legal);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_wr)      state_nxt = WR_ISSUE;
                else if (grant_rd) state_nxt = rd_legal ? RD_WAIT : RD_RESP;
            end
            WR_ISSUE: state_nxt = WR_RESP;
            WR_RESP:  if (s_bready) state_nxt = IDLE;
            RD_WAIT:  if (rd_done) state_nxt = RD_RESP;
            RD_RESP:  if (s_rready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant  <= GNT_RD;
            lat_cnt     <= '0;
            axi_wr_addr <= NOP_ADDR;
            axi_wr_msg  <= '0;
            axi_rd_addr <= NOP_ADDR;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            s_rvalid    <= 1'b0;
            s_rresp     <= RESP_OKAY;
            s_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wr) begin
                        last_grant <= GNT_WR;
                        if (wr_legal) begin
                            axi_wr_addr <= aw_q;
                            axi_wr_msg  <= w_data;
                        end
                    end else if (grant_rd) begin
                        last_grant <= GNT_RD;
                        lat_cnt    <= '0;
                        if (rd_legal) begin
                            axi_rd_addr <= ar_q;
                        end else begin
                            s_rvalid <= 1'b1;
                            s_rdata  <= '0;
                            s_rresp  <= RESP_SLVERR;
                        end
                    end
                end
                WR_ISSUE: begin
                    axi_wr_addr <= NOP_ADDR;
                    s_bvalid    <= 1'b1;
                    s_bresp     <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                end
                WR_RESP: if (s_bready) s_bvalid <= 1'b0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (rd_done) begin
                        s_rdata     <= axi_rd_msg;
                        s_rresp     <= RESP_OKAY;
                        s_rvalid    <= 1'b1;
                        axi_rd_addr <= NOP_ADDR;
                    end
                end
                RD_RESP: if (s_rready) s_rvalid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_front.sv
// Directed bench for axi_lite_front with RD_LAT=3: vector table plus hand-written
// sequences for buffering order, arbitration and reset during a transaction.
module tb_axi_lite_front;
    import axi_front_pkg::*;

    localparam int          RD_LAT = 3;
    localparam logic [31:0] NOP    = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] axi_wr_addr, axi_wr_msg, axi_rd_addr, axi_rd_msg;
    state_t      state_dbg;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] harness_data = 32'h0;
    int          hold_cnt = 0;
    int          rd_cycles = 0;
    logic [31:0] last_msg = 32'h0;

    axi_lite_front #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .axi_wr_addr(axi_wr_addr), .axi_wr_msg(axi_wr_msg),
        .axi_rd_addr(axi_rd_addr), .axi_rd_msg(axi_rd_msg),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Harness: read data is only valid once the address has been held RD_LAT cycles.
    always @(posedge clk) hold_cnt <= (axi_rd_addr != NOP) ? hold_cnt + 1 : 0;
    assign axi_rd_msg = (axi_rd_addr != NOP && hold_cnt >= RD_LAT - 1) ? harness_data : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard: forwarded harness writes ----------------
    always @(negedge clk) begin
        if (axi_rd_addr !== NOP) rd_cycles++;
        if (axi_wr_addr !== NOP) begin
            if (exp_q.size() == 0) check("wr_unexpected", {axi_wr_addr, axi_wr_msg}, {NOP, 32'h0});
            else                   check("wr_forward", {axi_wr_addr, axi_wr_msg}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (called and returning at negedge) ----------------
    task automatic send_all();
        logic aw_hs, w_hs, ar_hs;
        for (int t = 0; t < 40 && (s_awvalid || s_wvalid || s_arvalid); t++) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            ar_hs = s_arvalid && s_arready;
            @(negedge clk);
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid  = 1'b0;
            if (ar_hs) s_arvalid = 1'b0;
        end
        check("req_accept", {s_awvalid, s_wvalid, s_arvalid}, 64'h0);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        logic got = 1'b0;
        resp = 2'bxx;
        s_bready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (s_bvalid) begin
                resp = s_bresp;
                got  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b_timeout", got, 1);
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic wait_r(output logic [1:0] resp, output logic [31:0] data);
        logic got = 1'b0;
        resp = 2'bxx;
        data = 'x;
        s_rready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (s_rvalid) begin
                resp = s_rresp;
                data = s_rdata;
                got  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("r_timeout", got, 1);
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
    endtask

    task automatic check_reset_values();
        check("rst_rdy_vld", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 64'h0);
        check("rst_resp", {s_bresp, s_rresp}, 64'h0);
        check("rst_rdata", s_rdata, 64'h0);
        check("rst_wr_msg", axi_wr_msg, 64'h0);
        check("rst_addrs", {axi_wr_addr, axi_rd_addr}, {NOP, NOP});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_msg = 32'h0;
        @(negedge clk);
    endtask

    // Write and read captured in the same cycle; exp_order is {first,second}, 0=B 1=R.
    task automatic tie_pair(input string name, input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic [31:0] raddr, input logic [31:0] rdat, input logic [1:0] exp_order);
        logic [1:0]  seq = 2'b11;
        logic [31:0] got_rd = 'x;
        int          n = 0;
        exp_q.push_back({waddr, wdata});
        harness_data = rdat;
        drive_write(waddr, wdata, 4'hF);
        s_araddr = raddr; s_arvalid = 1'b1;
        send_all();
        s_bready = 1'b1; s_rready = 1'b1;
        for (int t = 0; t < 60 && n < 2; t++) begin
            if (s_bvalid) begin seq = {seq[0], 1'b0}; n++; end
            if (s_rvalid) begin seq = {seq[0], 1'b1}; got_rd = s_rdata; n++; end
            @(negedge clk);
        end
        s_bready = 1'b0; s_rready = 1'b0;
        check({name, "_order"}, seq, exp_order);
        check({name, "_rdata"}, got_rd, rdat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_rd;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or harness read data
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic        fwd;    // request reaches the harness bus
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0]  resp, b0;
        logic [31:0] rdat;
        int          bad, beats;
        logic        got;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY,   1'b1};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'h0, RESP_OKAY,   1'b1};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'hCAFE_F00D, 4'h3, RESP_SLVERR, 1'b0};
        vecs[3] = '{1'b0, NOP,           32'h1111_1111, 4'hF, RESP_SLVERR, 1'b0};
        vecs[4] = '{1'b1, NOP,           32'h0000_0055, 4'h0, RESP_SLVERR, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0007, 32'hA5A5_A5A5, 4'hF, RESP_OKAY,   1'b1};
        vecs[6] = '{1'b1, 32'h0000_0007, 32'h600D_F00D, 4'h0, RESP_OKAY,   1'b1};
        vecs[7] = '{1'b0, 32'hFFFF_FFF8, 32'h0000_0001, 4'hE, RESP_SLVERR, 1'b0};

        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {s_awready, s_wready, s_arready}, 64'h7);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_rd) begin
                harness_data = vecs[i].data;
                rd_cycles = 0;
                s_araddr = vecs[i].addr; s_arvalid = 1'b1;
                send_all();
                wait_r(resp, rdat);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_rdata", i), rdat, vecs[i].fwd ? vecs[i].data : 32'h0);
                check($sformatf("v%0d_rd_cycles", i), rd_cycles, vecs[i].fwd ? RD_LAT : 0);
            end else begin
                if (vecs[i].fwd) begin
                    exp_q.push_back({vecs[i].addr, vecs[i].data});
                    last_msg = vecs[i].data;
                end
                drive_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                send_all();
                wait_b(resp);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_wr_msg", i), axi_wr_msg, last_msg);
            end
        end

        // W arrives well before AW: entry stays full, nothing forwarded until AW lands.
        s_wdata = 32'h0BAD_CAFE; s_wstrb = 4'hF; s_wvalid = 1'b1;
        send_all();
        bad = 0;
        repeat (5) begin
            if (s_wready || !s_awready) bad++;
            @(negedge clk);
        end
        check("w_early_ready", bad, 0);
        exp_q.push_back({32'h20, 32'h0BAD_CAFE});
        s_awaddr = 32'h20; s_awvalid = 1'b1;
        send_all();
        wait_b(resp);
        check("w_early_bresp", resp, RESP_OKAY);

        // Arbitration alternates on ties.
        apply_reset();
        tie_pair("tie1", 32'h100, 32'h1111_0001, 32'h200, 32'h2222_0002, 2'b01);
        exp_q.push_back({32'h104, 32'h3333_0003});
        drive_write(32'h104, 32'h3333_0003, 4'hF);
        send_all();
        wait_b(resp);
        check("mid_bresp", resp, RESP_OKAY);
        tie_pair("tie2", 32'h108, 32'h4444_0004, 32'h204, 32'h5555_0005, 2'b10);

        // Stalled B stays stable while AR refills; then reset in RD_WAIT drops the read.
        exp_q.push_back({32'h30, 32'h0F0F_0F0F});
        drive_write(32'h30, 32'h0F0F_0F0F, 4'hF);
        send_all();
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (s_bvalid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("b_stall_seen", got, 1);
        b0 = s_bresp;
        harness_data = 32'h7777_0000;
        s_araddr = 32'h44; s_arvalid = 1'b1;
        send_all();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_bvalid !== 1'b1 || s_bresp !== b0) bad++;
        end
        check("b_stable", bad, 0);
        check("b_stall_resp", b0, RESP_OKAY);
        check("ar_held_ready", s_arready, 0);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (state_dbg == RD_WAIT) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("reach_rd_wait", got, 1);
        check("rd_addr_fwd", axi_rd_addr, 32'h44);
        s_rready = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        beats = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_rvalid) beats++;
        end
        check("no_r_after_rst", beats, 0);
        s_rready = 1'b0;

        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
